// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_sb register file and its busy-bit scoreboard.
package regfile_pkg;

  localparam int unsigned DefaultDataBits    = 32;
  localparam int unsigned DefaultAddressBits = 4;

  // One extra bit so the count can reach WORDS when every register is busy.
  function automatic int unsigned busy_cnt_bits(input int unsigned addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// Busy-bit scoreboard: per-register busy flags, set/clear/flush priority, popcount and RAW lookup.
// Build option REGFILE_ZERO_REG_EN keeps busy[0] permanently clear.
module busy_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned AddrBits = DefaultAddressBits,
  parameter int unsigned Words    = 1 << AddrBits
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [AddrBits-1:0]                  r_addr1_i,
  input  logic                                 r_use1_i,
  input  logic [AddrBits-1:0]                  r_addr2_i,
  input  logic                                 r_use2_i,
  input  logic [AddrBits-1:0]                  w_addr_i,
  input  logic                                 wrt_en_i,
  input  logic [AddrBits-1:0]                  iss_addr_i,
  input  logic                                 iss_en_i,
  input  logic                                 flush_i,
  output logic                                 hazard_o,
  output logic [Words-1:0]                     busy_vec_o,
  output logic [busy_cnt_bits(AddrBits)-1:0]   busy_cnt_o
);

  localparam int unsigned CntBits = busy_cnt_bits(AddrBits);

  logic [Words-1:0]   busy_q, busy_d;
  logic [Words-1:0]   wb_clear, iss_set;
  logic [CntBits-1:0] cnt_q, cnt_d;
  logic               byp1, byp2;
  logic               hazard;
  logic               iss_ok;

  // A writeback to the operand in the same cycle resolves the dependency.
  always_comb begin
    byp1   = wrt_en_i && (w_addr_i == r_addr1_i);
    byp2   = wrt_en_i && (w_addr_i == r_addr2_i);
    hazard = (r_use1_i && busy_q[r_addr1_i] && !byp1) ||
             (r_use2_i && busy_q[r_addr2_i] && !byp2);
  end

  assign hazard_o = hazard;

  always_comb begin
    iss_ok   = iss_en_i && !hazard && !flush_i;
    wb_clear = '0;
    iss_set  = '0;
    if (wrt_en_i) begin
      wb_clear[w_addr_i] = 1'b1;
    end
    if (iss_ok) begin
      iss_set[iss_addr_i] = 1'b1;
    end
`ifdef REGFILE_ZERO_REG_EN
    iss_set[0] = 1'b0;
`endif
    // Set is ORed in last so it wins over a same-address clear; flush already blocked the set.
    busy_d = (busy_q & ~wb_clear & ~{Words{flush_i}}) | iss_set;
    cnt_d  = '0;
    for (int unsigned i = 0; i < Words; i++) begin
      cnt_d = cnt_d + CntBits'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec_o = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with same-cycle write bypass and an integrated busy scoreboard.
// Build option REGFILE_ZERO_REG_EN hardwires register 0 to zero (never written, never busy).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DefaultDataBits,
  parameter int unsigned ADDRESS_BITS = DefaultAddressBits,
  parameter int unsigned WORDS        = 1 << ADDRESS_BITS
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [ADDRESS_BITS-1:0]                  r_addr1,
  input  logic                                     r_use1,
  output logic [DATA_BITS-1:0]                     d_out1,
  input  logic [ADDRESS_BITS-1:0]                  r_addr2,
  input  logic                                     r_use2,
  output logic [DATA_BITS-1:0]                     d_out2,
  input  logic [ADDRESS_BITS-1:0]                  w_addr,
  input  logic [DATA_BITS-1:0]                     d_in,
  input  logic                                     wrt_en,
  input  logic [ADDRESS_BITS-1:0]                  iss_addr,
  input  logic                                     iss_en,
  input  logic                                     flush,
  output logic                                     hazard,
  output logic [WORDS-1:0]                         busy_vec,
  output logic [busy_cnt_bits(ADDRESS_BITS)-1:0]   busy_cnt
);

  logic [DATA_BITS-1:0] mem_q [WORDS];
  logic                 wr_ok;

  always_comb begin
`ifdef REGFILE_ZERO_REG_EN
    wr_ok = wrt_en && (w_addr != '0);
`else
    wr_ok = wrt_en;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[w_addr] <= d_in;
    end
  end

  always_comb begin
    d_out1 = mem_q[r_addr1];
    d_out2 = mem_q[r_addr2];
    if (wr_ok && (w_addr == r_addr1)) begin
      d_out1 = d_in;
    end
    if (wr_ok && (w_addr == r_addr2)) begin
      d_out2 = d_in;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (r_addr1 == '0) begin
      d_out1 = '0;
    end
    if (r_addr2 == '0) begin
      d_out2 = '0;
    end
`endif
  end

  busy_scoreboard #(
    .AddrBits (ADDRESS_BITS),
    .Words    (WORDS)
  ) u_busy_scoreboard (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .r_addr1_i  (r_addr1),
    .r_use1_i   (r_use1),
    .r_addr2_i  (r_addr2),
    .r_use2_i   (r_use2),
    .w_addr_i   (w_addr),
    .wrt_en_i   (wrt_en),
    .iss_addr_i (iss_addr),
    .iss_en_i   (iss_en),
    .flush_i    (flush),
    .hazard_o   (hazard),
    .busy_vec_o (busy_vec),
    .busy_cnt_o (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default 32-bit data, 16 registers).
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  r_addr1, r_addr2, w_addr, iss_addr;
  logic        r_use1, r_use2, wrt_en, iss_en, flush;
  logic [31:0] d_in, d_out1, d_out2;
  logic        hazard;
  logic [15:0] busy_vec;
  logic [4:0]  busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  regfile_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_addr1  (r_addr1),
    .r_use1   (r_use1),
    .d_out1   (d_out1),
    .r_addr2  (r_addr2),
    .r_use2   (r_use2),
    .d_out2   (d_out2),
    .w_addr   (w_addr),
    .d_in     (d_in),
    .wrt_en   (wrt_en),
    .iss_addr (iss_addr),
    .iss_en   (iss_en),
    .flush    (flush),
    .hazard   (hazard),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r_use1 = 1'b0; r_use2 = 1'b0; wrt_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [3:0] a);
    iss_addr = a; iss_en = 1'b1;
    tick();
    iss_en = 1'b0;
  endtask

  task automatic wb(input logic [3:0] a, input logic [31:0] v);
    w_addr = a; d_in = v; wrt_en = 1'b1;
    tick();
    wrt_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    r_addr1 = '0; r_addr2 = '0; w_addr = '0; iss_addr = '0; d_in = '0;
    idle();
    #12;
    check("rst_busy_vec", busy_vec, 0);
    check("rst_busy_cnt", busy_cnt, 0);
    check("rst_hazard", hazard, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      r_addr1 = 4'(i); r_addr2 = 4'(15 - i);
      #1;
      check("rst_d_out1", d_out1, 0);
      check("rst_d_out2", d_out2, 0);
    end

    // Write-through bypass then registered read.
    w_addr = 4'd5; d_in = 32'hDEADBEEF; wrt_en = 1'b1; r_addr1 = 4'd5;
    #1;
    check("bypass_same_cycle", d_out1, 32'hDEADBEEF);
    tick();
    wrt_en = 1'b0; d_in = 32'h0;
    #1;
    check("bypass_next_cycle", d_out1, 32'hDEADBEEF);

    // RAW stall, ignored issue while stalled, release by writeback.
    issue(4'd3);
    r_use2 = 1'b1; r_addr2 = 4'd3; iss_addr = 4'd7; iss_en = 1'b1;
    #1;
    check("raw_hazard", hazard, 1);
    check("raw_busy_cnt", busy_cnt, 1);
    check("raw_busy_vec", busy_vec, 16'h0008);
    tick();
    check("raw_issue_ignored", busy_vec, 16'h0008);
    w_addr = 4'd3; d_in = 32'h42; wrt_en = 1'b1;
    #1;
    check("raw_release_hazard", hazard, 0);
    check("raw_release_data", d_out2, 32'h42);
    tick();
    idle();
    check("raw_held_issue_taken", busy_vec, 16'h0080);
    check("raw_held_issue_cnt", busy_cnt, 1);
    wb(4'd7, 32'h77);
    check("raw_cleared", busy_vec, 16'h0000);

    // Use bit qualifies the hazard on port 1.
    issue(4'd4);
    r_addr1 = 4'd4; r_use1 = 1'b0;
    #1;
    check("use_off_no_hazard", hazard, 0);
    r_use1 = 1'b1;
    #1;
    check("use_on_hazard", hazard, 1);
    r_use1 = 1'b0;

    // Same-cycle writeback and issue to the busy register: set wins.
    w_addr = 4'd4; d_in = 32'h44; wrt_en = 1'b1; iss_addr = 4'd4; iss_en = 1'b1;
    tick();
    idle();
    check("set_wins_busy", busy_vec, 16'h0010);
    check("set_wins_cnt", busy_cnt, 1);
    check("set_wins_data", d_out1, 32'h44);
    wb(4'd4, 32'h44);

    // Flush beats issue; writes still land.
    issue(4'd1);
    issue(4'd2);
    issue(4'd9);
    check("pre_flush_busy", busy_vec, 16'h0206);
    check("pre_flush_cnt", busy_cnt, 3);
    flush = 1'b1; iss_addr = 4'd6; iss_en = 1'b1; w_addr = 4'd2; d_in = 32'h11; wrt_en = 1'b1;
    tick();
    idle();
    r_addr1 = 4'd2;
    #1;
    check("flush_busy_vec", busy_vec, 16'h0000);
    check("flush_busy_cnt", busy_cnt, 0);
    check("flush_write_kept", d_out1, 32'h11);

    // Asynchronous reset mid-run with three busy registers.
    issue(4'd10);
    issue(4'd11);
    issue(4'd12);
    check("pre_reset_cnt", busy_cnt, 3);
    r_addr1 = 4'd5;
    #1;
    check("pre_reset_data", d_out1, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("midrst_busy_vec", busy_vec, 16'h0000);
    check("midrst_busy_cnt", busy_cnt, 0);
    check("midrst_data", d_out1, 0);
    #2;
    rst_n = 1'b1;
    tick();

    // Register 0: hardwired in the zero-register build, ordinary otherwise.
    w_addr = 4'd0; d_in = 32'h55; wrt_en = 1'b1; iss_addr = 4'd0; iss_en = 1'b1;
    tick();
    idle();
    r_addr1 = 4'd0; r_use1 = 1'b1;
    #1;
`ifdef REGFILE_ZERO_REG_EN
    check("zero_reg_data", d_out1, 0);
    check("zero_reg_busy", busy_vec[0], 0);
    check("zero_reg_hazard", hazard, 0);
`else
    check("reg0_data", d_out1, 32'h55);
    check("reg0_busy", busy_vec[0], 1);
    check("reg0_hazard", hazard, 1);
`endif
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised 2-read/1-write register file with an integrated busy-bit scoreboard for the pipelined processor. It replaces the plain register array in decode. Register contents are cleared on reset, and a same-cycle write is forwarded onto the read ports. Each register carries a busy bit, set when an instruction targeting it issues and cleared when its result is written back. The block raises `hazard` so decode stalls on RAW dependencies.

## Interface
Parameters:
- `DATA_BITS`, 32, width of each register
- `ADDRESS_BITS`, 4, register address width
- `WORDS`, `1 << ADDRESS_BITS`, number of registers

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `r_addr1`  in  ADDRESS_BITS  read port 1 address
- `r_use1`  in  1  read port 1 operand is consumed this cycle (qualifies hazard)
- `d_out1`  out  DATA_BITS  read port 1 data (combinational)
- `r_addr2`, `r_use2`, `d_out2`  same roles for read port 2
- `w_addr`  in  ADDRESS_BITS  writeback address
- `d_in`  in  DATA_BITS  writeback data
- `wrt_en`  in  1  writeback strobe; writes `d_in` and clears busy[`w_addr`]
- `iss_addr`  in  ADDRESS_BITS  destination of issuing instruction
- `iss_en`  in  1  issue request; accepted only when `hazard`=0 and `flush`=0
- `flush`  in  1  clears all busy bits (pipeline squash)
- `hazard`  out  1  RAW stall indication (combinational)
- `busy_vec`  out  WORDS  registered busy bits, bit i = register i
- `busy_cnt`  out  ADDRESS_BITS+1  registered count of set busy bits

## Operation
- **Reset (async, `rst_n`=0):** all registers go to 0, `busy_vec`=0 and `busy_cnt`=0. With `r_use`=0, `hazard`=0 and `d_out1`/`d_out2`=0.
- **Read:** `d_outN` = `d_in` when `wrt_en` and `w_addr`==`r_addrN`, else mem[`r_addrN`]. This forwards writeback data in the same cycle.
- **Hazard:** `hazard` = OR over N of (`r_useN` & busy[`r_addrN`] & !(`wrt_en` & `w_addr`==`r_addrN`)). A same-cycle writeback resolves the dependency.
- **Issue:** accepted = `iss_en` & !`hazard` & !`flush`. Accepted issue sets busy[`iss_addr`] at the next edge. `iss_en` while `hazard`=1 is ignored; the issuer must hold the request.
- **Writeback:** mem[`w_addr`] <= `d_in` and busy[`w_addr`] is cleared. A write to a non-busy register is legal; busy stays 0.
- **Busy next-state:** busy_next = (busy & ~wb_clear & ~{WORDS{flush}}) | issue_set.
  - Set wins over clear on the same address.
  - Flush wins over everything; issue is blocked while `flush`=1.
  - Writes still occur during flush.
- **Count:** `busy_cnt` always equals popcount(`busy_vec`), and is registered alongside it. Range is 0..WORDS, so no overflow is possible.
- A reset asserted mid-operation discards all pending busy state and register contents immediately.

## Timing
- Read data and `hazard` are combinational from address, use, and writeback inputs within the same cycle.
- A write becomes visible via mem one cycle after the edge; it is visible via bypass in the cycle it is presented.
- An accepted issue shows in `busy_vec`/`busy_cnt` one cycle later. A consumer reading that register in the next cycle sees `hazard`=1.
- Issue-to-stall-release latency equals the writeback cycle; there is no extra bubble.

## Configuration
- **`REGFILE_ZERO_REG_EN` defined:** register 0 is hardwired.
  - Reads of address 0 return 0, and there is no bypass to address 0.
  - Writes to 0 are dropped.
  - Issue to 0 never sets busy[0], so address 0 never hazards.
  - busy_vec[0] is constant 0.
- **Undefined:** register 0 is an ordinary register.

## Structure
- Shared package `regfile_pkg` holds:
  - default `DATA_BITS`/`ADDRESS_BITS` constants
  - a function computing the `busy_cnt` width
- One sub-module, `busy_scoreboard`, holds:
  - the busy-bit register
  - set/clear/flush priority logic
  - popcount register
  - hazard lookup for two read addresses
- The top holds the data array and the bypass muxes.

## Test plan
- **Reset contents:** reset, then read all 16 addresses → every `d_out`=0, `busy_cnt`=0, `hazard`=0. Assert `rst_n`=0 mid-run with 3 busy → next sample `busy_vec`=0.
- **Write-through bypass:** `wrt_en`=1, `w_addr`=5, `d_in`=0xDEADBEEF, `r_addr1`=5 in the same cycle → `d_out1`=0xDEADBEEF immediately; next cycle with `wrt_en`=0 → still 0xDEADBEEF.
- **RAW stall and release:**
  - Issue `iss_addr`=3; next cycle `r_use2`=1, `r_addr2`=3 → `hazard`=1, `busy_cnt`=1.
  - A concurrent `iss_en` to 7 is ignored.
  - Writeback 3 with 0x42 → `hazard`=0 that cycle and `d_out2`=0x42.
- **Set wins over clear:** reg 4 busy; same cycle `wrt_en`@4 and accepted issue@4 → busy[4] stays 1, `busy_cnt` unchanged.
- **Flush:** regs 1, 2, 9 busy; `flush`=1 with `iss_en`@6 and `wrt_en`@2 (0x11) → next cycle `busy_vec`=0, `busy_cnt`=0, reg 2 reads 0x11, busy[6]=0.
- **`REGFILE_ZERO_REG_EN` build:** write 0x55 to 0 and issue to 0 → `d_out1`@0=0, busy[0]=0, `hazard`=0 with `r_use1`@0.
